// File: rtl/sersub_pkg.sv
// Shared constants for the bit-serial subtractor: FSM state encoding and default width.
package sersub_pkg;
   localparam int unsigned SERSUB_WIDTH_DEFAULT = 8;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SHIFT = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;
endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: diff = a - b - bin with borrow out.
module full_subtractor (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic diff,
   output logic borrow
);
   assign diff   = a ^ b ^ bin;
   assign borrow = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a-b, LSB first, one bit per clock; result published on entry to DONE.
// Optional macro SERSUB_OVERFLOW_EN adds the two's-complement overflow output ovf.
module serial_subtractor
   import sersub_pkg::*;
#(
   parameter int unsigned WIDTH = SERSUB_WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
`ifdef SERSUB_OVERFLOW_EN
   output logic             ovf,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out
);
   localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, diff_q, diff_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             bor_q, bor_d, bout_q, bout_d;
   logic             fs_diff, fs_borrow;
`ifdef SERSUB_OVERFLOW_EN
   logic             ovf_q, ovf_d;
`endif

   full_subtractor u_fs (
      .a      (a_q[0]),
      .b      (b_q[0]),
      .bin    (bor_q),
      .diff   (fs_diff),
      .borrow (fs_borrow)
   );

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      cnt_d   = cnt_q;
      bor_d   = bor_q;
      diff_d  = diff_q;
      bout_d  = bout_q;
`ifdef SERSUB_OVERFLOW_EN
      ovf_d   = ovf_q;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               a_d     = a;
               b_d     = b;
               res_d   = '0;
               cnt_d   = '0;
               bor_d   = 1'b0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            bor_d = fs_borrow;
            res_d = {fs_diff, res_q[WIDTH-1:1]};
            a_d   = a_q >> 1;
            b_d   = b_q >> 1;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
               state_d = DONE;
               diff_d  = {fs_diff, res_q[WIDTH-1:1]};
               bout_d  = fs_borrow;
`ifdef SERSUB_OVERFLOW_EN
               // On the last shift the operand LSBs are the original sign bits.
               ovf_d   = (a_q[0] ^ b_q[0]) & (fs_diff ^ a_q[0]);
`endif
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         cnt_q   <= '0;
         bor_q   <= 1'b0;
         diff_q  <= '0;
         bout_q  <= 1'b0;
`ifdef SERSUB_OVERFLOW_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         cnt_q   <= cnt_d;
         bor_q   <= bor_d;
         diff_q  <= diff_d;
         bout_q  <= bout_d;
`ifdef SERSUB_OVERFLOW_EN
         ovf_q   <= ovf_d;
`endif
      end
   end

   assign busy       = (state_q == SHIFT);
   assign done       = (state_q == DONE);
   assign diff       = diff_q;
   assign borrow_out = bout_q;
`ifdef SERSUB_OVERFLOW_EN
   assign ovf        = ovf_q;
`endif
endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the operand and result width in bits (legal range 2..32).
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit; reset is synchronous and active-high.
REQ-004 SHALL have port start, input, 1 bit, a request to subtract the operands present on a and b.
REQ-005 SHALL have port a, input, WIDTH bits, the minuend.
REQ-006 SHALL have port b, input, WIDTH bits, the subtrahend.
REQ-007 SHALL have port busy, output, 1 bit, high while bits are being processed.
REQ-008 SHALL have port done, output, 1 bit, a one-cycle pulse when the result is ready.
REQ-009 SHALL have port diff, output, WIDTH bits, the result a-b modulo 2^WIDTH.
REQ-010 SHALL have port borrow_out, output, 1 bit, high when a<b unsigned.

Function
REQ-011 SHALL implement an FSM with three states: IDLE, SHIFT and DONE.
REQ-012 In IDLE, start=1 at edge E0 SHALL load a and b into shift registers, clear the borrow flop and the bit counter, and move to SHIFT.
REQ-013 Each SHIFT edge SHALL subtract the operand LSBs with the borrow flop as borrow-in, store the borrow, shift the difference bit in at the result MSB, and shift both operands right by one bit.
REQ-014 After the WIDTH-th SHIFT edge (edge E0+WIDTH), the FSM SHALL enter DONE and update diff and borrow_out together from the result register and the final borrow.
REQ-015 DONE SHALL last exactly one cycle (done=1) and then return to IDLE.
REQ-016 busy SHALL be 1 exactly in SHIFT, which is WIDTH cycles.
REQ-017 start SHALL be ignored in SHIFT and DONE; a and b SHALL be sampled only on the accepting edge.
REQ-018 diff and borrow_out SHALL hold their last values until the next completion.
REQ-019 Back-to-back operation: start held high SHALL be accepted in the IDLE cycle after DONE, giving a throughput of one result per WIDTH+2 cycles.

Reset
REQ-020 rst=1 SHALL force IDLE, set busy=0, done=0, diff=0, borrow_out=0, and clear the counter, borrow flop and shift registers.
REQ-021 rst asserted mid-operation SHALL abort the operation with no done pulse; reset SHALL take priority over start on the same edge.

Configuration
REQ-022 Macro SERSUB_OVERFLOW_EN, when defined, SHALL add an output ovf (1 bit) giving two's-complement overflow (a[MSB]!=b[MSB] and diff[MSB]!=a[MSB]).
REQ-023 ovf SHALL be updated with diff, reset to 0, and have the same timing as diff.
REQ-024 When SERSUB_OVERFLOW_EN is undefined, the port and its logic SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-025 A shared package sersub_pkg SHALL hold the FSM state encoding (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2) and the WIDTH default constant.
REQ-026 The per-bit arithmetic SHALL be one instance of sub-module full_subtractor (ports a, b, bin, diff, borrow; diff=a^b^bin, borrow=(~a&b)|(~(a^b)&bin)); there SHALL be no other sub-modules.

Verification
REQ-027 WIDTH=8, a=8'h05, b=8'h03, start pulse -> done exactly 8 edges after the accept edge, diff=8'h02, borrow_out=0.
REQ-028 a=8'h03, b=8'h05 -> diff=8'hFE, borrow_out=1; a=8'h00, b=8'h00 -> diff=8'h00, borrow_out=0.
REQ-029 a=8'h80, b=8'h01 -> diff=8'h7F, borrow_out=0, ovf=1 with macro defined; a=8'hFF, b=8'hFF -> diff=8'h00, ovf=0.
REQ-030 start re-pulsed with new operands during cycle 3 of SHIFT -> ignored; the first result is unchanged; busy stays high for exactly 8 cycles.
REQ-031 rst pulsed during cycle 4 of SHIFT -> next cycle has busy=0, diff=0, and no done pulse; a following start completes correctly.
REQ-032 start held high continuously -> done pulses every 10 cycles, each result correct for the operands sampled on its accept edge.
